// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: UART bridge frame layout, frame widths and FSM states shared by master and slave
package bus_bridge_pkg;
  localparam int TX_FRAME_W = 32;
  localparam int RX_FRAME_W = 16;
  localparam int ADDR_LSB   = 0;
  localparam int DATA_LSB   = 16;
  localparam int MODE_BIT   = 24;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_SEND,
    ST_TXWAIT,
    ST_RXWAIT,
    ST_RDATA
  } bb_state_e;
endpackage

// File: rtl/uart.sv
// uart: 8N1 byte UART, sends TX_WIDTH-bit words and receives RX_WIDTH-bit words LSB byte first
module uart #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int TX_WIDTH         = 32,
  parameter int RX_WIDTH         = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [TX_WIDTH-1:0] data_input,
  input  logic                data_en,
  output logic                tx,
  output logic                tx_busy,
  input  logic                rx,
  output logic [RX_WIDTH-1:0] data_output,
  output logic                ready
);
  localparam int CW  = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int TXB = TX_WIDTH / 8;
  localparam int RXB = RX_WIDTH / 8;
  localparam int TBW = $clog2(TXB + 1);
  localparam int RBW = $clog2(RXB + 1);
  logic                tx_q, tx_d, busy_q, busy_d;
  logic [TX_WIDTH-1:0] tsh_q, tsh_d;
  logic [CW-1:0]       tclk_q, tclk_d, rclk_q, rclk_d;
  logic [3:0]          tbit_q, tbit_d, rbit_q, rbit_d;
  logic [TBW-1:0]      tbyte_q, tbyte_d;
  logic [RBW-1:0]      rbyte_q, rbyte_d;
  logic [1:0]          rxs_q, rxs_d;
  logic                ract_q, ract_d, ready_q, ready_d;
  logic [RX_WIDTH-1:0] rsh_q, rsh_d, out_q, out_d;
  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign data_output = out_q;
  assign ready       = ready_q;
  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    tsh_d   = tsh_q;
    tclk_d  = tclk_q;
    tbit_d  = tbit_q;
    tbyte_d = tbyte_q;
    if (!busy_q) begin
      if (data_en) begin
        busy_d  = 1'b1;
        tsh_d   = data_input;
        tclk_d  = '0;
        tbit_d  = '0;
        tbyte_d = '0;
        tx_d    = 1'b0;
      end
    end else if (tclk_q != CW'(CLOCKS_PER_PULSE - 1)) begin
      tclk_d = tclk_q + 1'b1;
    end else begin
      tclk_d = '0;
      tbit_d = tbit_q + 1'b1;
      if (tbit_q == 4'd0) begin
        tx_d = tsh_q[0];
      end else if (tbit_q < 4'd8) begin
        tsh_d = tsh_q >> 1;
        tx_d  = tsh_q[1];
      end else if (tbit_q == 4'd8) begin
        tsh_d = tsh_q >> 1;
        tx_d  = 1'b1;
      end else begin
        tbit_d = '0;
        if (tbyte_q == TBW'(TXB - 1)) begin
          busy_d = 1'b0;
        end else begin
          tbyte_d = tbyte_q + 1'b1;
          tx_d    = 1'b0;
        end
      end
    end
  end
  always_comb begin
    rxs_d   = {rxs_q[0], rx};
    ract_d  = ract_q;
    rclk_d  = rclk_q;
    rbit_d  = rbit_q;
    rbyte_d = rbyte_q;
    rsh_d   = rsh_q;
    out_d   = out_q;
    ready_d = ready_q;
    if (!ract_q) begin
      if (!rxs_q[1]) begin
        ract_d  = 1'b1;
        rclk_d  = CW'(1);
        rbit_d  = '0;
        ready_d = 1'b0;
      end
    end else begin
      rclk_d = (rclk_q == CW'(CLOCKS_PER_PULSE - 1)) ? '0 : rclk_q + 1'b1;
      rbit_d = (rclk_q == CW'(CLOCKS_PER_PULSE - 1)) ? rbit_q + 1'b1 : rbit_q;
      if (rclk_q == CW'(CLOCKS_PER_PULSE / 2)) begin
        if (rbit_q == 4'd0) begin
          ract_d = ~rxs_q[1];
        end else if (rbit_q < 4'd9) begin
          rsh_d = {rxs_q[1], rsh_q[RX_WIDTH-1:1]};
        end else begin
          ract_d = 1'b0;
          if (rbyte_q == RBW'(RXB - 1)) begin
            rbyte_d = '0;
            out_d   = rsh_q;
            ready_d = 1'b1;
          end else begin
            rbyte_d = rbyte_q + 1'b1;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      tsh_q   <= '0;
      tclk_q  <= '0;
      tbit_q  <= '0;
      tbyte_q <= '0;
      rxs_q   <= 2'b11;
      ract_q  <= 1'b0;
      rclk_q  <= '0;
      rbit_q  <= '0;
      rbyte_q <= '0;
      rsh_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      tsh_q   <= tsh_d;
      tclk_q  <= tclk_d;
      tbit_q  <= tbit_d;
      tbyte_q <= tbyte_d;
      rxs_q   <= rxs_d;
      ract_q  <= ract_d;
      rclk_q  <= rclk_d;
      rbit_q  <= rbit_d;
      rbyte_q <= rbyte_d;
      rsh_q   <= rsh_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: rtl/bus_bridge_slave.sv
// bus_bridge_slave: serial bus slave that forwards requests as UART frames and returns read replies
module bus_bridge_slave
  import bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH            = 16,
  parameter int DATA_WIDTH            = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH  = 12,
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int RDATA_TIMEOUT         = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic swdata,
  input  logic smode,
  input  logic mvalid,
  output logic srdata,
  output logic svalid,
  output logic sready,
  output logic ssplit,
  output logic rd_timeout,
  output logic u_tx,
  input  logic u_rx
);
  localparam int SMAW = SLAVE_MEM_ADDR_WIDTH;
  localparam int CW   = $clog2((SMAW > DATA_WIDTH ? SMAW : DATA_WIDTH) + 1);
  localparam int TW   = $clog2(RDATA_TIMEOUT);
  bb_state_e             state_q, state_d;
  logic                  mode_q, mode_d, seen_busy_q, seen_busy_d, u_en_q, u_en_d;
  logic                  sready_q, sready_d, svalid_q, svalid_d, srdata_q, srdata_d;
  logic                  ssplit_q, ssplit_d, rd_timeout_q, rd_timeout_d, ready_prev_q, ready_prev_d;
  logic [SMAW-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rsh_q, rsh_d, rd_word;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [TX_FRAME_W-1:0] frame_q, frame_d;
  logic [RX_FRAME_W-1:0] rx_word;
  logic                  tx_busy, rx_ready, ready_rise, unused_rx;
  assign ready_rise = rx_ready & ~ready_prev_q;
  assign rd_word    = ready_rise ? rx_word[DATA_WIDTH-1:0] : '1;
  assign unused_rx  = ^rx_word[RX_FRAME_W-1:DATA_WIDTH];
  assign srdata     = srdata_q;
  assign svalid     = svalid_q;
  assign sready     = sready_q;
  assign ssplit     = ssplit_q;
  assign rd_timeout = rd_timeout_q;
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    seen_busy_d  = seen_busy_q;
    to_cnt_d     = to_cnt_q;
    frame_d      = frame_q;
    u_en_d       = 1'b0;
    rsh_d        = rsh_q;
    sready_d     = sready_q;
    svalid_d     = svalid_q;
    srdata_d     = srdata_q;
    ssplit_d     = ssplit_q;
    rd_timeout_d = rd_timeout_q;
    ready_prev_d = rx_ready;
    unique case (state_q)
      ST_IDLE: if (mvalid) begin
        mode_d   = smode;
        addr_d   = {swdata, addr_q[SMAW-1:1]};
        data_d   = '0;
        cnt_d    = CW'(1);
        sready_d = 1'b0;
        state_d  = ST_ADDR;
      end
      ST_ADDR: if (mvalid) begin
        addr_d = {swdata, addr_q[SMAW-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(SMAW - 1)) begin
          cnt_d   = '0;
          state_d = mode_q ? ST_WDATA : ST_SEND;
        end
      end
      ST_WDATA: if (mvalid) begin
        data_d = {swdata, data_q[DATA_WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        frame_d                           = '0;
        frame_d[MODE_BIT]                 = mode_q;
        frame_d[DATA_LSB +: DATA_WIDTH]   = data_q;
        frame_d[ADDR_LSB +: ADDR_WIDTH]   = ADDR_WIDTH'(addr_q);
        u_en_d                            = 1'b1;
        seen_busy_d                       = 1'b0;
        state_d                           = ST_TXWAIT;
      end
      ST_TXWAIT: if (tx_busy) begin
        seen_busy_d = 1'b1;
      end else if (seen_busy_q) begin
        state_d  = mode_q ? ST_IDLE : ST_RXWAIT;
        sready_d = mode_q;
        ssplit_d = ~mode_q;
        to_cnt_d = '0;
      end
      ST_RXWAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // a reply landing on the timeout cycle still wins over the timeout
        if (ready_rise || to_cnt_q == TW'(RDATA_TIMEOUT - 1)) begin
          srdata_d     = rd_word[0];
          rsh_d        = rd_word >> 1;
          svalid_d     = 1'b1;
          ssplit_d     = 1'b0;
          rd_timeout_d = rd_timeout_q | ~ready_rise;
          cnt_d        = CW'(1);
          state_d      = ST_RDATA;
        end
      end
      ST_RDATA: if (cnt_q == CW'(DATA_WIDTH)) begin
        svalid_d = 1'b0;
        srdata_d = 1'b0;
        sready_d = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end else begin
        srdata_d = rsh_q[0];
        rsh_d    = rsh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      seen_busy_q  <= 1'b0;
      to_cnt_q     <= '0;
      frame_q      <= '0;
      u_en_q       <= 1'b0;
      rsh_q        <= '0;
      sready_q     <= 1'b1;
      svalid_q     <= 1'b0;
      srdata_q     <= 1'b0;
      ssplit_q     <= 1'b0;
      rd_timeout_q <= 1'b0;
      ready_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      seen_busy_q  <= seen_busy_d;
      to_cnt_q     <= to_cnt_d;
      frame_q      <= frame_d;
      u_en_q       <= u_en_d;
      rsh_q        <= rsh_d;
      sready_q     <= sready_d;
      svalid_q     <= svalid_d;
      srdata_q     <= srdata_d;
      ssplit_q     <= ssplit_d;
      rd_timeout_q <= rd_timeout_d;
      ready_prev_q <= ready_prev_d;
    end
  end
  uart #(
    .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
    .TX_WIDTH        (TX_FRAME_W),
    .RX_WIDTH        (RX_FRAME_W)
  ) u_uart (
    .clk        (clk),
    .rstn       (rstn),
    .data_input (frame_q),
    .data_en    (u_en_q),
    .tx         (u_tx),
    .tx_busy    (tx_busy),
    .rx         (u_rx),
    .data_output(rx_word),
    .ready      (rx_ready)
  );
endmodule

// File: tb/tb_bus_bridge_slave.sv
// tb_bus_bridge_slave: directed bench for bus_bridge_slave with a behavioural UART peer
module tb_bus_bridge_slave;
  logic clk = 1'b0, rstn = 1'b0, swdata = 1'b0, smode = 1'b0, mvalid = 1'b0, u_rx = 1'b1;
  logic srdata, svalid, sready, ssplit, rd_timeout, u_tx;
  int total = 0, bad = 0, sv_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (svalid === 1'b1) sv_cnt <= sv_cnt + 1;
  bus_bridge_slave #(
    .UART_CLOCKS_PER_PULSE(4),
    .RDATA_TIMEOUT        (2000)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .swdata    (swdata),
    .smode     (smode),
    .mvalid    (mvalid),
    .srdata    (srdata),
    .svalid    (svalid),
    .sready    (sready),
    .ssplit    (ssplit),
    .rd_timeout(rd_timeout),
    .u_tx      (u_tx),
    .u_rx      (u_rx)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      mvalid = 1'b0;
    end
  endtask
  task automatic send_req(input logic m, input logic [11:0] a, input logic [7:0] dt,
                          input int sa, input int na, input int sd, input int nd);
    for (int i = 0; i < 12; i++) begin
      if (i == sa) stall(na);
      @(negedge clk);
      mvalid = 1'b1;
      smode  = m;
      swdata = a[i];
    end
    if (m) for (int i = 0; i < 8; i++) begin
      if (i == sd) stall(nd);
      @(negedge clk);
      mvalid = 1'b1;
      swdata = dt[i];
    end
    @(negedge clk);
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask
  task automatic uart_get(output logic [31:0] f, output logic ok);
    f  = '0;
    ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (u_tx !== 1'b0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        f[b*8+k] = u_tx;
      end
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic uart_put(input logic [15:0] v);
    for (int b = 0; b < 2; b++) begin
      logic [9:0] fr;
      fr = {1'b1, v[b*8 +: 8], 1'b0};
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        u_rx = fr[k];
        repeat (3) @(negedge clk);
      end
    end
  endtask
  task automatic collect(input int budget, output logic [7:0] d, output int n);
    int t;
    t = 0;
    d = '0;
    n = 0;
    @(negedge clk);
    while (svalid !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    while (svalid === 1'b1 && n < 16) begin
      if (n < 8) d[n] = srdata;
      n++;
      @(negedge clk);
    end
  endtask
  task automatic wait_ready(output logic ok);
    int t;
    t = 0;
    while (sready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = (sready === 1'b1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] f;
    logic [7:0]  d;
    logic        ok;
    int          n, base;
    repeat (3) @(negedge clk);
    chk("rst_sready", sready, 1);
    chk("rst_svalid", svalid, 0);
    chk("rst_srdata", srdata, 0);
    chk("rst_ssplit", ssplit, 0);
    chk("rst_rdto", rd_timeout, 0);
    chk("rst_utx", u_tx, 1);
    rstn = 1'b1;
    base = sv_cnt;
    send_req(1'b1, 12'h0A5, 8'h3C, -1, 0, -1, 0);
    chk("wr_busy", sready, 0);
    uart_get(f, ok);
    chk("wr_got", ok, 1);
    chk("wr_frame", f, 32'h013C00A5);
    wait_ready(ok);
    chk("wr_sready", ok, 1);
    chk("wr_nosvalid", sv_cnt - base, 0);
    send_req(1'b0, 12'hFFF, 8'h00, -1, 0, -1, 0);
    uart_get(f, ok);
    chk("rd_frame", f, 32'h00000FFF);
    repeat (10) @(negedge clk);
    chk("rd_split", ssplit, 1);
    chk("rd_busy", sready, 0);
    fork
      uart_put(16'h005A);
      collect(400, d, n);
    join
    chk("rd_data", d, 8'h5A);
    chk("rd_len", n, 8);
    chk("rd_split_clr", ssplit, 0);
    wait_ready(ok);
    chk("rd_sready", ok, 1);
    chk("rd_noto", rd_timeout, 0);
    send_req(1'b1, 12'h0A5, 8'h3C, 5, 3, 3, 2);
    uart_get(f, ok);
    chk("stall_frame", f, 32'h013C00A5);
    wait_ready(ok);
    chk("stall_sready", ok, 1);
    send_req(1'b0, 12'h123, 8'h00, -1, 0, -1, 0);
    uart_get(f, ok);
    chk("to_frame", f, 32'h00000123);
    collect(2600, d, n);
    chk("to_data", d, 8'hFF);
    chk("to_len", n, 8);
    chk("to_flag", rd_timeout, 1);
    wait_ready(ok);
    chk("to_sready", ok, 1);
    send_req(1'b0, 12'h001, 8'h00, -1, 0, -1, 0);
    uart_get(f, ok);
    chk("rst_rd_frame", f, 32'h00000001);
    repeat (10) @(negedge clk);
    chk("rst_rd_split", ssplit, 1);
    rstn = 1'b0;
    #1;
    chk("mid_sready", sready, 1);
    chk("mid_ssplit", ssplit, 0);
    chk("mid_svalid", svalid, 0);
    chk("mid_rdto", rd_timeout, 0);
    chk("mid_utx", u_tx, 1);
    @(negedge clk);
    rstn = 1'b1;
    base = sv_cnt;
    uart_put(16'h00AB);
    repeat (20) @(negedge clk);
    chk("late_nosvalid", sv_cnt - base, 0);
    chk("late_sready", sready, 1);
    send_req(1'b1, 12'h7FF, 8'h81, -1, 0, -1, 0);
    uart_get(f, ok);
    chk("post_frame", f, 32'h018107FF);
    wait_ready(ok);
    chk("post_sready", ok, 1);
    base = sv_cnt;
    uart_put(16'h1234);
    repeat (20) @(negedge clk);
    chk("unsol_nosvalid", sv_cnt - base, 0);
    chk("unsol_sready", sready, 1);
    chk("unsol_ssplit", ssplit, 0);
    send_req(1'b0, 12'h456, 8'h00, -1, 0, -1, 0);
    uart_get(f, ok);
    chk("last_frame", f, 32'h00000456);
    fork
      uart_put(16'h00C3);
      collect(400, d, n);
    join
    chk("last_data", d, 8'hC3);
    chk("last_len", n, 8);
    chk("last_noto", rd_timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_bridge_slave.md
Name: bus_bridge_slave

Overview:
- Remote end of the UART bus bridge. Sits on the local serial bus as a slave.
- Deserialises bus write and read requests and packs each one into a 32-bit UART frame `{mode, data, addr}`. This is the same frame layout that bus_bridge_master decodes on the other board.
- For reads, waits for a 16-bit UART reply and serialises the returned byte back onto the bus.
- Instantiates the existing uart module with TX width 32 and RX width 16. The widths are mirrored relative to bus_bridge_master.

Parameters:
- ADDR_WIDTH, 16, width of the UART frame address field.
- DATA_WIDTH, 8, bus data width.
- SLAVE_MEM_ADDR_WIDTH, 12, number of serial address bits received from the bus.
- UART_CLOCKS_PER_PULSE, 5208, UART bit period in clk cycles.
- RDATA_TIMEOUT, 1000000, cycles to wait for the UART read reply before aborting.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- swdata  in  1  serial address/write data, LSB first
- smode  in  1  0 = read, 1 = write; sampled with the first address bit
- mvalid  in  1  swdata bit valid
- srdata  out  1  serial read data, LSB first
- svalid  out  1  srdata bit valid
- sready  out  1  slave idle, can accept a request
- ssplit  out  1  high while waiting on the remote read reply
- rd_timeout  out  1  sticky; set when a read reply times out
- u_tx  out  1  UART transmit line
- u_rx  in  1  UART receive line

Behaviour:

Reset and outputs:
- Reset is asynchronous and active-low. All flops clear immediately; the uart instance gets the same rstn.
- Reset values: sready=1, svalid=0, srdata=0, ssplit=0, rd_timeout=0, u_en=0. The FSM goes to IDLE and all counters are 0.
- Reset mid-transfer abandons the transfer. No partial UART frame is re-sent after reset.
- All outputs are registered.

FSM states: IDLE, ADDR, WDATA, SEND, TXWAIT, RXWAIT, RDATA.
- IDLE:
  - sready=1.
  - On mvalid=1: capture swdata as address bit 0 and latch smode, drive sready=0, set bit count=1, go to ADDR.
- ADDR:
  - Each mvalid=1 cycle shifts in the next address bit. mvalid=0 stalls without counting.
  - After SLAVE_MEM_ADDR_WIDTH bits: go to WDATA if mode=1, else go to SEND.
- WDATA:
  - Shift in DATA_WIDTH bits under the same mvalid stall rule, then go to SEND.
- SEND:
  - Build the frame:
    - bit [DATA_WIDTH+ADDR_WIDTH] = mode
    - bits [ADDR_WIDTH +: DATA_WIDTH] = data (zero for a read)
    - bits [ADDR_WIDTH-1:0] = address, zero-extended from SLAVE_MEM_ADDR_WIDTH
    - all upper bits = 0
  - Pulse u_en for exactly 1 cycle, then go to TXWAIT.
- TXWAIT:
  - Wait for tx_busy to rise and then fall (a seen_busy flag tracks the rise).
  - On completion: a write goes to IDLE; a read goes to RXWAIT with ssplit=1 and timeout counter=0.
- RXWAIT:
  - The timeout counter increments every cycle.
  - On a rising edge of the uart ready output: latch data_output[DATA_WIDTH-1:0], drive ssplit=0, go to RDATA.
  - If the counter reaches RDATA_TIMEOUT-1 first: set read data to all-ones, set rd_timeout, drive ssplit=0, go to RDATA.
  - If ready rises on the same cycle as the timeout, the received data wins and rd_timeout is not set.
- RDATA:
  - svalid=1 for DATA_WIDTH consecutive cycles; srdata carries bit k in the k-th cycle.
  - Then svalid=0, sready=1, back to IDLE.
- The ready-edge detector runs continuously, so a UART reply arriving outside RXWAIT is discarded.
- mvalid is ignored outside IDLE, ADDR and WDATA.
- rd_timeout is cleared only by reset.

Latency and timing:
- From the last request bit to u_en: 2 cycles.
- From the ready rise to the first svalid: 1 cycle.

Decomposition:
- Shared package (bus_bridge_pkg), shared with bus_bridge_master:
  - frame field offsets MODE_BIT, DATA_LSB, ADDR_LSB
  - UART frame widths 32 and 16
  - FSM state enum
- Sub-module: the existing uart, instantiated once.
- The serial shift logic is inline; no new sub-module.

Test Plan:
Bench settings: UART_CLOCKS_PER_PULSE=4, RDATA_TIMEOUT=2000.
- Write: mode=1, addr=0x0A5, data=0x3C, contiguous mvalid → UART TB model receives 0x013C00A5; sready returns high after TX completes; svalid never asserts.
- Read: mode=0, addr=0xFFF → frame 0x00000FFF sent; ssplit=1; TB replies 0x005A → ssplit falls; svalid high for 8 cycles with srdata=0,1,0,1,1,0,1,0.
- Stalled request: mvalid deasserted for 3 cycles mid-address and 2 cycles mid-data → frame identical to the contiguous case.
- Timeout: read with no UART reply → after 2000 cycles rd_timeout=1, serialised data 0xFF, FSM back in IDLE.
- Reset mid-read: assert rstn=0 during RXWAIT → outputs immediately take reset values; a late reply is ignored; the next write works normally.
- Unsolicited UART reply while IDLE → no svalid; state unchanged.
